// File: rtl/alu4b_issue_unit_if.sv
// Instruction issue handshake between an instruction source (master) and
// alu4b_issue_unit (slave). Valid/ready: a transfer happens on a rising edge
// where both ins_valid and ins_ready are high.
interface alu4b_issue_if #(
    parameter int DATA_W = 4,
    parameter int RA_W   = 3
) ();
    logic              ins_valid;
    logic              ins_ready;
    logic [3:0]        ins_op;
    logic [RA_W-1:0]   ins_rd;
    logic [RA_W-1:0]   ins_rs1;
    logic [RA_W-1:0]   ins_rs2;
    logic              ins_imm_en;
    logic [DATA_W-1:0] ins_imm;

    modport master (
        output ins_valid, ins_op, ins_rd, ins_rs1, ins_rs2, ins_imm_en, ins_imm,
        input  ins_ready
    );

    modport slave (
        input  ins_valid, ins_op, ins_rd, ins_rs1, ins_rs2, ins_imm_en, ins_imm,
        output ins_ready
    );
endinterface

// File: rtl/alu4b_issue_unit.sv
// alu4b_issue_unit: registered, stateful wrapper around the combinational
// ALU4B. Accepts one instruction per three cycles (IDLE -> EXEC -> WB), reads
// operands from an internal register file, drives the ALU for the EXEC cycle,
// captures its result and flags, and writes back in WB.
//
// Optional feature macro: ALU4B_ISSUE_R0_ZERO_EN
//   defined   - register 0 reads as 0 and writes to it are discarded
//               (flags and done still behave normally).
//   undefined - register 0 is an ordinary register.
module alu4b_issue_unit #(
    parameter int DATA_W = 4,
    parameter int NREGS  = 8,
    parameter int RA_W   = 3
) (
    input  logic              clk,
    input  logic              reset,
    alu4b_issue_if.slave      ins,
    output logic [DATA_W-1:0] alu_in1,
    output logic [DATA_W-1:0] alu_in2,
    output logic [3:0]        alu_op,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_zero,
    input  logic              alu_negative,
    output logic              done,
    output logic              flag_zero,
    output logic              flag_negative,
    input  logic [RA_W-1:0]   dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t            state_q;
    logic              ready_q;
    logic              done_q;
    logic [RA_W-1:0]   rd_q;
    logic [DATA_W-1:0] alu_in1_q;
    logic [DATA_W-1:0] alu_in2_q;
    logic [3:0]        alu_op_q;
    logic [DATA_W-1:0] result_q;
    logic              zero_q;
    logic              negative_q;
    logic              flag_zero_q;
    logic              flag_negative_q;

    logic [DATA_W-1:0] rf_q [NREGS];
    logic [NREGS-1:0]  wr_en;
    logic              wb_fire;

    assign wb_fire = (state_q == WB);

    // Per-register write enable decoded from the latched destination.
    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_wr_en
`ifdef ALU4B_ISSUE_R0_ZERO_EN
            if (gi == 0) begin : g_r0
                assign wr_en[gi] = 1'b0;
            end else begin : g_rn
                assign wr_en[gi] = wb_fire && (rd_q == RA_W'(gi));
            end
`else
            assign wr_en[gi] = wb_fire && (rd_q == RA_W'(gi));
`endif
        end
    endgenerate

    // Register file: cleared by reset, written only during WB.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (wr_en[i]) begin
                    rf_q[i] <= result_q;
                end
            end
        end
    end

    // Issue FSM with registered handshake, ALU-drive, done and flag outputs.
    // Operands are fetched at the accept edge: no register can change between
    // accept and EXEC, so this equals reading them during EXEC.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            ready_q         <= 1'b1;
            done_q          <= 1'b0;
            rd_q            <= '0;
            alu_in1_q       <= '0;
            alu_in2_q       <= '0;
            alu_op_q        <= '0;
            result_q        <= '0;
            zero_q          <= 1'b0;
            negative_q      <= 1'b0;
            flag_zero_q     <= 1'b0;
            flag_negative_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ins.ins_valid) begin
                        state_q   <= EXEC;
                        ready_q   <= 1'b0;
                        rd_q      <= ins.ins_rd;
                        alu_op_q  <= ins.ins_op;
                        alu_in1_q <= rf_q[ins.ins_rs1];
                        alu_in2_q <= ins.ins_imm_en ? ins.ins_imm : rf_q[ins.ins_rs2];
                    end
                end
                EXEC: begin
                    result_q   <= alu_out;
                    zero_q     <= alu_zero;
                    negative_q <= alu_negative;
                    done_q     <= 1'b1;
                    state_q    <= WB;
                end
                WB: begin
                    flag_zero_q     <= zero_q;
                    flag_negative_q <= negative_q;
                    done_q          <= 1'b0;
                    ready_q         <= 1'b1;
                    alu_in1_q       <= '0;
                    alu_in2_q       <= '0;
                    alu_op_q        <= '0;
                    state_q         <= IDLE;
                end
                default: begin
                    state_q   <= IDLE;
                    ready_q   <= 1'b1;
                    done_q    <= 1'b0;
                    alu_in1_q <= '0;
                    alu_in2_q <= '0;
                    alu_op_q  <= '0;
                end
            endcase
        end
    end

    assign ins.ins_ready = ready_q;
    assign done          = done_q;
    assign alu_in1       = alu_in1_q;
    assign alu_in2       = alu_in2_q;
    assign alu_op        = alu_op_q;
    assign flag_zero     = flag_zero_q;
    assign flag_negative = flag_negative_q;
    assign dbg_data      = rf_q[dbg_addr];

endmodule

// File: tb/tb_alu4b_issue_unit.sv
// Self-checking bench for alu4b_issue_unit. A behavioural ALU4B drives the
// result/flag inputs; expected writebacks are pushed to a scoreboard queue on
// accept and popped when done is observed.
module tb_alu4b_issue_unit;
    localparam int DATA_W = 4;
    localparam int NREGS  = 8;
    localparam int RA_W   = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu4b_issue_if #(.DATA_W(DATA_W), .RA_W(RA_W)) ins ();

    logic [3:0] alu_in1, alu_in2, alu_op, alu_out;
    logic       alu_zero, alu_negative, done, flag_zero, flag_negative;
    logic [2:0] dbg_addr;
    logic [3:0] dbg_data;

    alu4b_issue_unit #(.DATA_W(DATA_W), .NREGS(NREGS), .RA_W(RA_W)) dut (
        .clk(clk), .reset(reset), .ins(ins),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op),
        .alu_out(alu_out), .alu_zero(alu_zero), .alu_negative(alu_negative),
        .done(done), .flag_zero(flag_zero), .flag_negative(flag_negative),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    // Behavioural ALU4B subset: 0000 add, 1001 subtract, 0100 and, else or.
    function automatic logic [3:0] alu_fn(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
        case (op)
            4'b0000: alu_fn = a + b;
            4'b1001: alu_fn = a - b;
            4'b0100: alu_fn = a & b;
            default: alu_fn = a | b;
        endcase
    endfunction

    assign alu_out      = alu_fn(alu_op, alu_in1, alu_in2);
    assign alu_zero     = (alu_out == 4'd0);
    assign alu_negative = alu_out[3];

    typedef struct {
        logic [2:0] rd;
        logic [3:0] op;
        logic [3:0] in1;
        logic [3:0] in2;
        logic [3:0] res;
        logic       z;
        logic       n;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] model_rf[NREGS];
    logic       model_z, model_n;
    int         n_checks = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         last_acc = -100;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic read_reg(input logic [2:0] a, output logic [3:0] v);
        dbg_addr = a;
        #1;
        v = dbg_data;
    endtask

    task automatic model_clear();
        for (int i = 0; i < NREGS; i++) model_rf[i] = 4'd0;
        model_z = 1'b0;
        model_n = 1'b0;
    endtask

    // Issue one instruction starting just after a negedge; returns just after
    // the negedge of the IDLE cycle following writeback.
    task automatic run_instr(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                             input logic [2:0] rs2, input logic imm_en, input logic [3:0] imm,
                             input bit hold, input bit chk_rate);
        exp_t e, p;
        int   w;
        int   acc;
        ins.ins_valid = 1'b1; ins.ins_op = op; ins.ins_rd = rd; ins.ins_rs1 = rs1;
        ins.ins_rs2 = rs2; ins.ins_imm_en = imm_en; ins.ins_imm = imm;
        w = 0;
        while (ins.ins_ready !== 1'b1 && w < 8) begin
            @(negedge clk);
            w++;
        end
        if (ins.ins_ready !== 1'b1) begin
            n_checks++; n_fail++;
            $display("FAIL accept_timeout: ins_ready=%b required 1 within 8 cycles", ins.ins_ready);
            ins.ins_valid = 1'b0;
            return;
        end
        e.rd = rd; e.op = op; e.in1 = model_rf[rs1];
        e.in2 = imm_en ? imm : model_rf[rs2];
        e.res = alu_fn(op, e.in1, e.in2);
        e.z = (e.res == 4'd0); e.n = e.res[3];
        sb.push_back(e);
        acc = cyc;
        if (chk_rate) begin
            n_checks++;
            if (acc - last_acc !== 3) begin
                n_fail++;
                $display("FAIL accept_rate: got %0d cycles between accepts, required 3", acc - last_acc);
            end
        end
        last_acc = acc;
        @(posedge clk);
        $display("accept op=%b rd=%0d rs1=%0d rs2=%0d imm_en=%b imm=%b -> expect %b z=%b n=%b",
                 op, rd, rs1, rs2, imm_en, imm, e.res, e.z, e.n);
        // EXEC cycle: scramble ins_* to show they are ignored while busy.
        @(negedge clk);
        ins.ins_valid = hold; ins.ins_op = ~op; ins.ins_rd = rd + 3'd1;
        ins.ins_rs1 = rs1 + 3'd1; ins.ins_rs2 = rs2 + 3'd1; ins.ins_imm = ~imm;
        n_checks++;
        if (ins.ins_ready !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL exec_ctrl: ready=%b done=%b, required 0 0", ins.ins_ready, done);
        end
        n_checks++;
        if (alu_in1 !== e.in1 || alu_in2 !== e.in2 || alu_op !== e.op) begin
            n_fail++;
            $display("FAIL exec_operands: in1=%b in2=%b op=%b, required %b %b %b",
                     alu_in1, alu_in2, alu_op, e.in1, e.in2, e.op);
        end
        // WB cycle: done pulses, ALU inputs held, flags not yet updated.
        @(negedge clk);
        n_checks++;
        if (done !== 1'b1 || ins.ins_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL wb_ctrl: done=%b ready=%b, required 1 0", done, ins.ins_ready);
        end
        n_checks++;
        if (alu_in1 !== e.in1 || alu_in2 !== e.in2 || alu_op !== e.op) begin
            n_fail++;
            $display("FAIL wb_hold: in1=%b in2=%b op=%b, required %b %b %b",
                     alu_in1, alu_in2, alu_op, e.in1, e.in2, e.op);
        end
        n_checks++;
        if (flag_zero !== model_z || flag_negative !== model_n) begin
            n_fail++;
            $display("FAIL wb_flags_early: z=%b n=%b, required old %b %b", flag_zero, flag_negative, model_z, model_n);
        end
        if (sb.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL sb_underflow: queue size 0, required 1");
            return;
        end
        p = sb.pop_front();
`ifdef ALU4B_ISSUE_R0_ZERO_EN
        if (p.rd != 3'd0) model_rf[p.rd] = p.res;
`else
        model_rf[p.rd] = p.res;
`endif
        model_z = p.z;
        model_n = p.n;
        // IDLE cycle: result visible, flags updated, ALU inputs cleared.
        @(negedge clk);
        dbg_addr = p.rd;
        #1;
        n_checks++;
        if (done !== 1'b0 || ins.ins_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_ctrl: done=%b ready=%b, required 0 1", done, ins.ins_ready);
        end
        n_checks++;
        if (alu_in1 !== 4'd0 || alu_in2 !== 4'd0 || alu_op !== 4'd0) begin
            n_fail++;
            $display("FAIL idle_alu_zero: in1=%b in2=%b op=%b, required 0", alu_in1, alu_in2, alu_op);
        end
        n_checks++;
        if (dbg_data !== model_rf[p.rd]) begin
            n_fail++;
            $display("FAIL writeback: reg%0d=%b, required %b", p.rd, dbg_data, model_rf[p.rd]);
        end
        n_checks++;
        if (flag_zero !== p.z || flag_negative !== p.n) begin
            n_fail++;
            $display("FAIL flags: z=%b n=%b, required %b %b", flag_zero, flag_negative, p.z, p.n);
        end
    endtask

    task automatic test_reset();
        logic [3:0] v;
        reset = 1'b1; ins.ins_valid = 1'b0; ins.ins_op = 4'd0; ins.ins_rd = 3'd0;
        ins.ins_rs1 = 3'd0; ins.ins_rs2 = 3'd0; ins.ins_imm_en = 1'b0; ins.ins_imm = 4'd0;
        dbg_addr = 3'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        n_checks++;
        if (ins.ins_ready !== 1'b1 || done !== 1'b0 || flag_zero !== 1'b0 || flag_negative !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: ready=%b done=%b z=%b n=%b, required 1 0 0 0",
                     ins.ins_ready, done, flag_zero, flag_negative);
        end
        n_checks++;
        if (alu_in1 !== 4'd0 || alu_in2 !== 4'd0 || alu_op !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_alu: in1=%b in2=%b op=%b, required 0", alu_in1, alu_in2, alu_op);
        end
        for (int i = 0; i < NREGS; i++) begin
            read_reg(3'(i), v);
            n_checks++;
            if (v !== 4'd0) begin
                n_fail++;
                $display("FAIL reset_reg%0d: got %b, required 0000", i, v);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_load_imm();
        logic [3:0] v;
        run_instr(4'b0000, 3'd1, 3'd0, 3'd0, 1'b1, 4'b0011, 1'b0, 1'b0);
        read_reg(3'd1, v);
        n_checks++;
        if (v !== 4'b0011 || flag_zero !== 1'b0 || flag_negative !== 1'b0) begin
            n_fail++;
            $display("FAIL load_imm: reg1=%b z=%b n=%b, required 0011 0 0", v, flag_zero, flag_negative);
        end
    endtask

    task automatic test_add();
        logic [3:0] v;
        run_instr(4'b0000, 3'd2, 3'd0, 3'd0, 1'b1, 4'b0101, 1'b0, 1'b0);
        run_instr(4'b0000, 3'd3, 3'd1, 3'd2, 1'b0, 4'b1010, 1'b0, 1'b0);
        read_reg(3'd3, v);
        n_checks++;
        if (v !== 4'b1000 || flag_zero !== 1'b0 || flag_negative !== 1'b1) begin
            n_fail++;
            $display("FAIL add: reg3=%b z=%b n=%b, required 1000 0 1", v, flag_zero, flag_negative);
        end
    endtask

    task automatic test_overflow();
        logic [3:0] v;
        run_instr(4'b0000, 3'd1, 3'd0, 3'd0, 1'b1, 4'b0001, 1'b0, 1'b0);
        run_instr(4'b0000, 3'd2, 3'd0, 3'd0, 1'b1, 4'b1111, 1'b0, 1'b0);
        run_instr(4'b0000, 3'd4, 3'd1, 3'd2, 1'b0, 4'b0000, 1'b0, 1'b0);
        read_reg(3'd4, v);
        n_checks++;
        if (v !== 4'b0000 || flag_zero !== 1'b1 || flag_negative !== 1'b0) begin
            n_fail++;
            $display("FAIL overflow: reg4=%b z=%b n=%b, required 0000 1 0", v, flag_zero, flag_negative);
        end
    endtask

    task automatic test_sub_inplace();
        logic [3:0] v;
        run_instr(4'b0000, 3'd1, 3'd0, 3'd0, 1'b1, 4'b0011, 1'b0, 1'b0);
        run_instr(4'b0000, 3'd2, 3'd0, 3'd0, 1'b1, 4'b0101, 1'b0, 1'b0);
        run_instr(4'b1001, 3'd1, 3'd1, 3'd2, 1'b0, 4'b0000, 1'b0, 1'b0);
        read_reg(3'd1, v);
        n_checks++;
        if (v !== 4'b1110 || flag_zero !== 1'b0 || flag_negative !== 1'b1) begin
            n_fail++;
            $display("FAIL sub_inplace: reg1=%b z=%b n=%b, required 1110 0 1", v, flag_zero, flag_negative);
        end
    endtask

    task automatic test_back_to_back();
        run_instr(4'b0000, 3'd5, 3'd0, 3'd0, 1'b1, 4'b0110, 1'b1, 1'b0);
        run_instr(4'b0000, 3'd6, 3'd5, 3'd0, 1'b1, 4'b0011, 1'b1, 1'b1);
        run_instr(4'b1001, 3'd7, 3'd6, 3'd5, 1'b0, 4'b0000, 1'b1, 1'b1);
        run_instr(4'b0100, 3'd3, 3'd6, 3'd0, 1'b1, 4'b1100, 1'b1, 1'b1);
        run_instr(4'b0010, 3'd2, 3'd3, 3'd7, 1'b0, 4'b0000, 1'b0, 1'b1);
        n_checks++;
        if (sb.size() !== 0) begin
            n_fail++;
            $display("FAIL b2b_scoreboard: %0d entries left, required 0", sb.size());
        end
    endtask

    task automatic test_r0();
        logic [3:0] v;
        logic [3:0] want;
`ifdef ALU4B_ISSUE_R0_ZERO_EN
        want = 4'b0000;
`else
        want = 4'b0110;
`endif
        run_instr(4'b0000, 3'd0, 3'd0, 3'd0, 1'b1, 4'b0110, 1'b0, 1'b0);
        read_reg(3'd0, v);
        n_checks++;
        if (v !== want) begin
            n_fail++;
            $display("FAIL r0_write: reg0=%b, required %b", v, want);
        end
        run_instr(4'b0000, 3'd4, 3'd0, 3'd0, 1'b1, 4'b0001, 1'b0, 1'b0);
    endtask

    task automatic test_midop_reset();
        logic [3:0] v;
        int         w;
        bit         saw_done;
        // Leave a nonzero flag behind so the reset clear is observable.
        run_instr(4'b0000, 3'd6, 3'd0, 3'd0, 1'b1, 4'b1000, 1'b0, 1'b0);
        ins.ins_valid = 1'b1; ins.ins_op = 4'b0000; ins.ins_rd = 3'd5; ins.ins_rs1 = 3'd0;
        ins.ins_rs2 = 3'd0; ins.ins_imm_en = 1'b1; ins.ins_imm = 4'b0111;
        w = 0;
        while (ins.ins_ready !== 1'b1 && w < 8) begin
            @(negedge clk);
            w++;
        end
        n_checks++;
        if (ins.ins_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midop_accept_timeout: ins_ready=%b required 1", ins.ins_ready);
        end
        @(posedge clk);
        $display("accept op=0000 rd=5 imm=0111 (reset during EXEC)");
        @(negedge clk);
        ins.ins_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        n_checks++;
        if (ins.ins_ready !== 1'b1 || done !== 1'b0 || flag_zero !== 1'b0 || flag_negative !== 1'b0) begin
            n_fail++;
            $display("FAIL midop_state: ready=%b done=%b z=%b n=%b, required 1 0 0 0",
                     ins.ins_ready, done, flag_zero, flag_negative);
        end
        saw_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done !== 1'b0) saw_done = 1'b1;
        end
        n_checks++;
        if (saw_done) begin
            n_fail++;
            $display("FAIL midop_done: done pulsed after reset, required no pulse");
        end
        for (int i = 0; i < NREGS; i++) begin
            read_reg(3'(i), v);
            n_checks++;
            if (v !== 4'd0) begin
                n_fail++;
                $display("FAIL midop_reg%0d: got %b, required 0000", i, v);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_load_imm();
        test_add();
        test_overflow();
        test_sub_inplace();
        test_back_to_back();
        test_r0();
        test_midop_reset();
        n_checks++;
        if (sb.size() !== 0) begin
            n_fail++;
            $display("FAIL final_scoreboard: %0d entries left, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute time bound in case something stalls outside the bounded waits.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/alu4b_issue_unit.md
Name: alu4b_issue_unit

Overview:
- Sequencing stage that sits directly upstream of the combinational ALU4B and also captures its results.
- Accepts one ALU instruction per valid/ready handshake and reads operands from a small internal register file.
- Drives the ALU4B operand and opcode inputs for one cycle, then writes the result back to the register file and updates the zero/negative flag register.
- Gives the MHRD-style CPU datapath a registered, stateful wrapper around the ALU.

Parameters:
- DATA_W, 4, data width; must match ALU4B bus width.
- NREGS, 8, number of general registers.
- RA_W, 3, register address width; clog2(NREGS).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- ins_valid  input  1  instruction present.
- ins_ready  output  1  unit can accept an instruction.
- ins_op  input  4  ALU4B opCode, forwarded unchanged.
- ins_rd  input  RA_W  destination register.
- ins_rs1  input  RA_W  source register for in1.
- ins_rs2  input  RA_W  source register for in2.
- ins_imm_en  input  1  1: in2 = ins_imm instead of reg[rs2].
- ins_imm  input  DATA_W  immediate operand.
- alu_in1  output  DATA_W  to ALU4B in1.
- alu_in2  output  DATA_W  to ALU4B in2.
- alu_op  output  4  to ALU4B opCode.
- alu_out  input  DATA_W  from ALU4B out.
- alu_zero  input  1  from ALU4B zero.
- alu_negative  input  1  from ALU4B negative.
- done  output  1  one-cycle pulse when writeback occurs.
- flag_zero  output  1  registered zero flag of last completed instruction.
- flag_negative  output  1  registered negative flag of last completed instruction.
- dbg_addr  input  RA_W  debug read address.
- dbg_data  output  DATA_W  combinational reg[dbg_addr].

Behaviour:
- Reset (synchronous, active-high; wins over every other event, including mid-operation):
  - state=IDLE; all registers=0; flag_zero=0, flag_negative=0; done=0.
  - alu_in1, alu_in2 and alu_op are 0 in IDLE.
  - An in-flight instruction is dropped with no writeback.
- FSM states IDLE, EXEC, WB:
  - IDLE: ins_ready=1. When ins_valid=1, latch op, rd, rs1, rs2, imm_en and imm; go to EXEC. When ins_valid=0, stay.
  - EXEC: ins_ready=0.
    - alu_in1=reg[rs1_q].
    - alu_in2 = imm_en_q ? imm_q : reg[rs2_q].
    - alu_op=op_q.
    - At the end of the cycle, sample alu_out, alu_zero and alu_negative into result registers; go to WB.
  - WB: ins_ready=0; done=1. At the end of the cycle, reg[rd_q]=result, flag_zero=zero_q, flag_negative=negative_q; go to IDLE.
- ALU-driving outputs are held at the latched values during WB and return to 0 in IDLE.
- Latency and throughput:
  - Handshake at edge N.
  - EXEC during cycle N+1.
  - done high during cycle N+2; register visible on dbg_data from cycle N+3.
  - Next accept no earlier than edge N+3, giving 1 instruction per 3 cycles.
- Hazards: writeback completes before the next EXEC reads operands, so no forwarding is needed.
  - rd may equal rs1 or rs2; the old value is used as the operand and the new value is written.
- Operand values are latched in EXEC. Values on ins_* while ins_ready=0 are ignored.
- Flags:
  - Flags change only at WB.
  - Flags come from ALU4B, not from recomputation.
  - Overflow wraps modulo 2^DATA_W, exactly as ALU4B does.
- ins_valid may drop without acceptance, and there is no requirement to hold it.

Optional Feature:
- Macro: ALU4B_ISSUE_R0_ZERO_EN.
- Defined:
  - Register 0 is hardwired to 0; writes with rd=0 are discarded.
  - flag_zero and flag_negative still update and done still pulses.
  - dbg_data for address 0 is always 0.
- Undefined: register 0 is an ordinary writable register, reset to 0.

Test Plan:
- Load immediate: reset; issue op=0000, rd=1, rs1=0, imm_en=1, imm=0011 -> done pulses 2 cycles after accept; dbg reg1=0011; flags z=0, n=0.
- Add: load reg2=0101 the same way; issue op=0000, rd=3, rs1=1, rs2=2 -> reg3=1000, flag_negative=1, flag_zero=0.
- Overflow: reg1=0001 and reg2=1111 (loaded via immediates); issue op=0000, rd=4, rs1=1, rs2=2 -> reg4=0000, flag_zero=1, flag_negative=0.
- Subtract with in-place write: reg1=0011, reg2=0101; issue op=1001, rd=1, rs1=1, rs2=2 -> reg1=1110, n=1; alu_in1 was 0011 during EXEC.
- Handshake: hold ins_valid=1 continuously with distinct instructions -> ins_ready high only in IDLE; exactly one accept per 3 cycles; no instruction lost or duplicated.
- Mid-op reset: assert reset during EXEC of op=0000, rd=5, imm=0111 -> no done pulse; reg5=0; flags=0; ins_ready=1 the cycle after reset deasserts.
